// File: rtl/rx.sv
// Console keyboard receiver: async 8N1 deserialiser with flag/overrun/framing status.
module rx #(
   parameter logic [13:0] BIT_CNT  = 14'd10416,
   parameter logic [13:0] HALF_CNT = 14'd5207
) (
   input  logic       clk100,
   input  logic       reset,
   input  logic       clear,
   input  logic       rx_in,
   input  logic       clear_flag,
   output logic [0:7] char,
   output logic       flag,
   output logic       overrun,
   output logic       framing_err
);

   localparam int unsigned CNT_W = 14;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   logic [1:0]       sync_q;
   logic             rxs;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [0:7]       shreg_q, shreg_d;
   logic [0:7]       char_d;
   logic             flag_d, overrun_d, framing_err_d;
   logic             cnt_zero;

   assign rxs      = sync_q[1];
   assign cnt_zero = (cnt_q == CNT_W'(0));

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk100) begin
      if (reset || clear) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_in};
      end
   end

   // State register and all receive datapath/status registers.
   always_ff @(posedge clk100) begin
      if (reset || clear) begin
         state_q     <= ST_IDLE;
         cnt_q       <= CNT_W'(0);
         bit_idx_q   <= IDX_W'(0);
         shreg_q     <= 8'o000;
         char        <= 8'o000;
         flag        <= 1'b0;
         overrun     <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         char        <= char_d;
         flag        <= flag_d;
         overrun     <= overrun_d;
         framing_err <= framing_err_d;
      end
   end

   // Next-state, bit timing, shifting and status flag logic.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
      bit_idx_d     = bit_idx_q;
      shreg_d       = shreg_q;
      char_d        = char;
      flag_d        = flag;
      overrun_d     = overrun;
      framing_err_d = framing_err;

      // KCC/KRB strobe; a load in the same cycle overrides the flag below.
      if (clear_flag) begin
         flag_d        = 1'b0;
         overrun_d     = 1'b0;
         framing_err_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (!rxs) begin
               cnt_d   = HALF_CNT;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_zero) begin
               if (!rxs) begin
                  cnt_d     = BIT_CNT;
                  bit_idx_d = IDX_W'(0);
                  state_d   = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (cnt_zero) begin
               // LSB arrives first and ends up in char[7].
               shreg_d = {rxs, shreg_q[0:6]};
               cnt_d   = BIT_CNT;
               if (bit_idx_q == IDX_W'(7)) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end
         end
         ST_STOP: begin
            if (cnt_zero) begin
               if (rxs) begin
                  char_d = shreg_q;
                  flag_d = 1'b1;
                  if (flag && !clear_flag) begin
                     overrun_d = 1'b1;
                  end
                  state_d = ST_IDLE;
               end else begin
                  framing_err_d = 1'b1;
                  state_d       = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // A held-low line must return high before a new start bit counts.
            if (rxs) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rx.sv
// Directed bench for the console keyboard receiver at 16 cycles per bit.
module tb_rx;

   logic       clk100;
   logic       reset;
   logic       clear;
   logic       rx_in;
   logic       clear_flag;
   logic [0:7] char;
   logic       flag;
   logic       overrun;
   logic       framing_err;

   int unsigned total;
   int unsigned passed;

   rx #(
      .BIT_CNT (14'd15),
      .HALF_CNT(14'd7)
   ) dut (
      .clk100     (clk100),
      .reset      (reset),
      .clear      (clear),
      .rx_in      (rx_in),
      .clear_flag (clear_flag),
      .char       (char),
      .flag       (flag),
      .overrun    (overrun),
      .framing_err(framing_err)
   );

   initial clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk100);
      #1;
   endtask

   task automatic hold(input logic lvl, input int n);
      rx_in = lvl;
      repeat (n) tick();
   endtask

   // Start bit plus eight data bits, LSB first; leaves the caller at the stop bit.
   task automatic frame_body(input logic [7:0] b);
      hold(1'b0, 16);
      for (int i = 0; i < 8; i++) hold(b[i], 16);
   endtask

   task automatic send(input logic [7:0] b);
      frame_body(b);
      hold(1'b1, 16);
      hold(1'b1, 4);
   endtask

   task automatic pulse_clear_flag();
      clear_flag = 1'b1;
      tick();
      clear_flag = 1'b0;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
   endtask

   initial begin
      total      = 0;
      passed     = 0;
      reset      = 1'b1;
      clear      = 1'b0;
      rx_in      = 1'b1;
      clear_flag = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_char", char, 8'o000);
      check("rst_flag", 8'(flag), 8'd0);
      check("rst_ovr", 8'(overrun), 8'd0);
      check("rst_fe", 8'(framing_err), 8'd0);
      hold(1'b1, 5);

      // 1: single character, flag rises one cycle after the stop sample
      frame_body(8'o215);
      hold(1'b1, 10);
      check("t1_flag_early", 8'(flag), 8'd0);
      tick();
      check("t1_flag", 8'(flag), 8'd1);
      check("t1_char", char, 8'o215);
      check("t1_ovr", 8'(overrun), 8'd0);
      check("t1_fe", 8'(framing_err), 8'd0);
      hold(1'b1, 9);

      // 2: second character without clear gives overrun
      send(8'o042);
      check("t2_char", char, 8'o042);
      check("t2_flag", 8'(flag), 8'd1);
      check("t2_ovr", 8'(overrun), 8'd1);
      pulse_clear_flag();
      check("t2_clr_flag", 8'(flag), 8'd0);
      check("t2_clr_ovr", 8'(overrun), 8'd0);
      check("t2_clr_char", char, 8'o042);

      // 3: short low glitch is rejected, following frame still received
      hold(1'b0, 4);
      hold(1'b1, 12);
      check("t3_glitch_flag", 8'(flag), 8'd0);
      check("t3_glitch_char", char, 8'o042);
      send(8'o101);
      check("t3_char", char, 8'o101);
      check("t3_flag", 8'(flag), 8'd1);
      pulse_clear_flag();

      // 4: stop bit held low produces framing error, then normal frame
      frame_body(8'o377);
      hold(1'b0, 40);
      check("t4_fe", 8'(framing_err), 8'd1);
      check("t4_flag", 8'(flag), 8'd0);
      check("t4_char", char, 8'o101);
      hold(1'b1, 8);
      send(8'o060);
      check("t4_char2", char, 8'o060);
      check("t4_flag2", 8'(flag), 8'd1);

      // 5: clear_flag coincident with the load cycle while flag is set
      frame_body(8'o252);
      hold(1'b1, 10);
      clear_flag = 1'b1;
      tick();
      clear_flag = 1'b0;
      check("t5_flag", 8'(flag), 8'd1);
      check("t5_ovr", 8'(overrun), 8'd0);
      check("t5_char", char, 8'o252);
      hold(1'b1, 9);

      // 6: clear mid-frame during data bit 3 (line high from bit 3 on)
      hold(1'b0, 16);
      hold(1'b0, 48);
      hold(1'b1, 8);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t6_char", char, 8'o000);
      check("t6_flag", 8'(flag), 8'd0);
      check("t6_ovr", 8'(overrun), 8'd0);
      check("t6_fe", 8'(framing_err), 8'd0);
      hold(1'b1, 7 + 64 + 16 + 4);
      check("t6_idle_flag", 8'(flag), 8'd0);
      send(8'o125);
      check("t6_char2", char, 8'o125);
      check("t6_flag2", 8'(flag), 8'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
